// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN streaming blocks: the pooling mode encoding
// and a signed max helper used by the pooling datapaths.
package cnn_pkg;

    // Pooling mode encoding, as seen on the mode input and held in mode_q.
    localparam logic POOL_MAX = 1'b0;
    localparam logic POOL_AVG = 1'b1;

    // Operand width of the max helper. Callers sign-extend into it and
    // truncate the result back, so any pixel width up to SMAX_W-2 fits.
    localparam int SMAX_W = 32;

    // Signed maximum of two two's-complement values.
    function automatic logic signed [SMAX_W-1:0] smax(
        input logic signed [SMAX_W-1:0] a,
        input logic signed [SMAX_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// One-row buffer of horizontal partial results. An even input row writes the
// pair results here; the following odd row reads them back to finish each
// 2x2 window. Single write port, single combinational read port.
module pool_line_buffer #(
    parameter int DEPTH = 14,
    parameter int WIDTH = 17,
    parameter int AW    = 4
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic signed [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]           rd_addr,
    output logic signed [WIDTH-1:0] rd_data
);

    logic signed [WIDTH-1:0] mem [DEPTH];

    // Store a horizontal partial result for the current column pair.
    // NOTE: the storage has no reset; every entry is written on an even row
    // before the odd row that reads it, so its power-up value never matters.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pool2d_stream.sv
// Streaming 2x2 / stride-2 pooling engine (max or average) for a D-channel
// HxW feature map delivered one pixel per cycle in channel-major raster order.
// Pooled pixels leave in the same order behind a one-entry output register
// with valid/ready handshaking on both sides.
module pool2d_stream
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int D          = 6,
    parameter int H          = 28,
    parameter int W          = 28,
    parameter int CW         = (D > 1) ? $clog2(D) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         mode,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CW-1:0]                out_ch,
    output logic                         frame_done
);

    // Counter widths and datapath widths. A horizontal pair sum needs one
    // extra bit; the full four-pixel sum needs two.
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);
    localparam int AW = (W / 2 > 1) ? $clog2(W / 2) : 1;
    localparam int BW = DATA_WIDTH + 1;
    localparam int SW = DATA_WIDTH + 2;

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] c;
    logic          x_last;
    logic          y_last;
    logic          c_last;
    logic          frame_start;

    logic          accept;
    logic          emit;
    logic          mode_q;
    logic          last_q;

    logic signed [DATA_WIDTH-1:0] hreg;
    logic signed [SW-1:0]         h;
    logic signed [SW-1:0]         v;
    logic signed [BW-1:0]         buf_rd;
    logic [AW-1:0]                col;

    // Input may be taken whenever the output register is empty or draining.
    assign in_ready    = !out_valid || out_ready;
    assign accept      = in_valid && in_ready;

    assign x_last      = (x == XW'(W - 1));
    assign y_last      = (y == YW'(H - 1));
    assign c_last      = (c == CW'(D - 1));
    assign frame_start = (x == '0) && (y == '0) && (c == '0);

    // An odd column on an odd row completes a 2x2 window.
    assign emit        = accept && x[0] && y[0];
    assign col         = AW'(x >> 1);

    // Raster position counters: column, row, channel; they move only on accept.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x <= '0;
            y <= '0;
            c <= '0;
        end else if (accept) begin
            if (x_last) begin
                x <= '0;
                if (y_last) begin
                    y <= '0;
                    c <= c_last ? '0 : c + 1'b1;
                end else begin
                    y <= y + 1'b1;
                end
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    // Latch the pooling mode on the first pixel of a frame; held until the next frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q <= POOL_MAX;
        end else if (accept && frame_start) begin
            mode_q <= mode;
        end
    end

    // Hold the left pixel of each horizontal pair until its partner arrives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hreg <= '0;
        end else if (accept && !x[0]) begin
            hreg <= in_data;
        end
    end

    // Horizontal pair result and full window result for the pixel on in_data.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // can leave it unassigned and infer a latch.
        h = '0;
        v = '0;
        if (mode_q == POOL_AVG) begin
            h = SW'(hreg) + SW'(in_data);
            // Arithmetic shift floors toward -inf; the quotient always fits
            // back into DATA_WIDTH because it lies between the input extremes.
            v = (SW'(buf_rd) + h) >>> 2;
        end else begin
            h = SW'(smax(SMAX_W'(hreg), SMAX_W'(in_data)));
            v = SW'(smax(SMAX_W'(buf_rd), SMAX_W'(h)));
        end
    end

    // Even rows park their pair results; odd rows read them back at the same column.
    pool_line_buffer #(
        .DEPTH (W / 2),
        .WIDTH (BW),
        .AW    (AW)
    ) u_line_buffer (
        .clk     (clk),
        .wr_en   (accept && x[0] && !y[0]),
        .wr_addr (col),
        .wr_data (BW'(h)),
        .rd_addr (col),
        .rd_data (buf_rd)
    );

    // Output register: load on a completed window, clear on handshake, otherwise hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            last_q    <= 1'b0;
        end else if (emit) begin
            out_valid <= 1'b1;
            out_data  <= v[DATA_WIDTH-1:0];
            out_ch    <= c;
            last_q    <= c_last && y_last && x_last;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Pulse once when the final pooled pixel of the frame is handed downstream.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= out_valid && out_ready && last_q;
        end
    end

endmodule

// File: tb/tb_pool2d_stream.sv
// Scoreboard bench for pool2d_stream with D=2, H=W=4, 16-bit pixels.
// The stimulus process pushes the expected pooled pixel when it offers the
// pixel that completes a window; a monitor pops and compares on each output
// handshake and also checks the frame_done pulse.
module tb_pool2d_stream;

    localparam int DW   = 16;
    localparam int D    = 2;
    localparam int H    = 4;
    localparam int W    = 4;
    localparam int NPX  = D * H * W;
    localparam int NOUT = D * (H / 2) * (W / 2);

    typedef logic signed [DW-1:0] px_t;

    typedef struct {
        px_t data;
        int  ch;
        bit  last;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       mode;
    px_t        in_data;
    logic       in_valid;
    logic       in_ready;
    px_t        out_data;
    logic       out_valid;
    logic       out_ready;
    logic [0:0] out_ch;
    logic       frame_done;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];
    px_t  fr [NPX];
    px_t  ex [NOUT];
    bit   bp_hold    = 1'b0;
    bit   rand_ready = 1'b0;
    bit   gaps       = 1'b0;
    bit   exp_done   = 1'b0;

    pool2d_stream #(
        .DATA_WIDTH (DW),
        .D          (D),
        .H          (H),
        .W          (W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ch     (out_ch),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Downstream ready: forced low during a hold, optionally random, else high.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (bp_hold)         out_ready = 1'b0;
            else if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
            else                 out_ready = 1'b1;
        end
    end

    // Monitor: compare each handed-over output and the frame_done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (frame_done || exp_done) begin
                check("frame_done", int'(frame_done), int'(exp_done));
            end
            exp_done = 1'b0;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got data %0d ch %0d, expected none", out_data, out_ch);
                end else begin
                    e = q.pop_front();
                    check("out_data", int'(out_data), int'(e.data));
                    check("out_ch", int'(out_ch), e.ch);
                    exp_done = e.last;
                end
            end
        end
    end

    // Offer one pixel and wait until it is accepted.
    task automatic send_px(input px_t v, input logic m);
        bit ok;
        int n;
        ok = 1'b0;
        n  = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        in_data  = v;
        mode     = m;
        in_valid = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!ok) timeout_fail("accept_wait");
    endtask

    // Hold downstream for 5 cycles with a result pending and the next pixel offered.
    task automatic hold_check(input px_t held, input px_t next_px);
        bp_hold  = 1'b1;
        in_data  = next_px;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_out_valid", int'(out_valid), 1);
            check("hold_in_ready", int'(in_ready), 0);
            check("hold_out_data", int'(out_data), int'(held));
            @(posedge clk);
            #1;
        end
        bp_hold = 1'b0;
    endtask

    // Stream a whole frame from fr, queueing ex entries as windows complete.
    task automatic send_frame(input logic m0, input logic mr, input bit rand_mode, input int hold_at);
        int   ch, yy, xx, k;
        exp_t e;
        for (int i = 0; i < NPX; i++) begin
            ch = i / (H * W);
            yy = (i % (H * W)) / W;
            xx = i % W;
            if ((xx % 2 == 1) && (yy % 2 == 1)) begin
                k      = ch * (H / 2) * (W / 2) + (yy / 2) * (W / 2) + xx / 2;
                e.data = ex[k];
                e.ch   = ch;
                e.last = (k == NOUT - 1);
                q.push_back(e);
            end
            if (i == 0)         send_px(fr[i], m0);
            else if (rand_mode) send_px(fr[i], 1'($urandom_range(0, 1)));
            else                send_px(fr[i], mr);
            if (i == hold_at) hold_check(ex[0], fr[i + 1]);
        end
    endtask

    task automatic set_block(input int ch, input int b, input int a0, input int a1, input int a2, input int a3);
        int base;
        base            = ch * H * W + (b / 2) * 2 * W + (b % 2) * 2;
        fr[base]        = px_t'(a0);
        fr[base + 1]    = px_t'(a1);
        fr[base + W]    = px_t'(a2);
        fr[base + W + 1] = px_t'(a3);
    endtask

    task automatic set_ex(input int e0, input int e1, input int e2, input int e3,
                          input int e4, input int e5, input int e6, input int e7);
        ex[0] = px_t'(e0); ex[1] = px_t'(e1); ex[2] = px_t'(e2); ex[3] = px_t'(e3);
        ex[4] = px_t'(e4); ex[5] = px_t'(e5); ex[6] = px_t'(e6); ex[7] = px_t'(e7);
    endtask

    // Ramp frame: channel 0 holds 0..15, channel 1 holds 15..0.
    task automatic fill_ramp();
        for (int i = 0; i < H * W; i++) begin
            fr[i]         = px_t'(i);
            fr[H * W + i] = px_t'(15 - i);
        end
    endtask

    // Frame-level reference: pool each 2x2 window of fr directly.
    task automatic model(input logic m);
        int base, s, mx, k;
        int a [4];
        for (int ch = 0; ch < D; ch++) begin
            for (int by = 0; by < H / 2; by++) begin
                for (int bx = 0; bx < W / 2; bx++) begin
                    base = ch * H * W + by * 2 * W + bx * 2;
                    a[0] = int'(fr[base]);
                    a[1] = int'(fr[base + 1]);
                    a[2] = int'(fr[base + W]);
                    a[3] = int'(fr[base + W + 1]);
                    s  = a[0] + a[1] + a[2] + a[3];
                    mx = a[0];
                    for (int j = 1; j < 4; j++) if (a[j] > mx) mx = a[j];
                    k = ch * (H / 2) * (W / 2) + by * (W / 2) + bx;
                    ex[k] = (m == 1'b1) ? px_t'(s >>> 2) : px_t'(mx);
                end
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q.size() != 0) timeout_fail("drain_wait");
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        exp_t e;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        mode     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_ch", int'(out_ch), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Max: channel 0 = 0..15, channel 1 = 0,-1..-15.
        for (int i = 0; i < H * W; i++) begin
            fr[i]         = px_t'(i);
            fr[H * W + i] = px_t'(-i);
        end
        set_ex(5, 7, 13, 15, 0, -2, -8, -10);
        send_frame(1'b0, 1'b0, 1'b0, -1);

        // Average, back to back: floor rounding, both extremes, small sums.
        for (int i = 0; i < NPX; i++) fr[i] = '0;
        set_block(0, 0, -1, -2, -3, -4);
        set_block(0, 1, 32767, 32767, 32767, 32767);
        set_block(0, 2, -32768, -32768, -32768, -32768);
        set_block(0, 3, 1, 2, 3, 5);
        set_block(1, 0, 7, 0, 0, 0);
        set_block(1, 1, -7, 0, 0, 0);
        set_block(1, 2, 3, 3, 3, 3);
        set_block(1, 3, -1, 0, 0, 0);
        set_ex(-3, 32767, -32768, 2, 1, -2, 3, -1);
        send_frame(1'b1, 1'b1, 1'b0, -1);

        // Max with a 5-cycle downstream hold after the first result.
        fill_ramp();
        set_ex(5, 7, 13, 15, 15, 13, 7, 5);
        send_frame(1'b0, 1'b0, 1'b0, 5);

        // Mode high only on the first pixel: the whole frame averages.
        set_ex(2, 4, 10, 12, 12, 10, 4, 2);
        send_frame(1'b1, 1'b0, 1'b0, -1);

        // Random data, random input gaps, random ready, mode wiggling mid-frame.
        rand_ready = 1'b1;
        gaps       = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < NPX; i++) fr[i] = px_t'($urandom);
            model(1'(f));
            send_frame(1'(f), 1'b0, 1'b1, -1);
        end
        rand_ready = 1'b0;
        gaps       = 1'b0;
        drain();

        // Reset mid-frame with a result pending in the output register.
        fill_ramp();
        for (int i = 0; i < 7; i++) begin
            if (i == 5) begin
                e.data = px_t'(5);
                e.ch   = 0;
                e.last = 1'b0;
                q.push_back(e);
            end
            send_px(fr[i], 1'b0);
        end
        bp_hold = 1'b1;
        send_px(fr[7], 1'b0);
        check("pre_rst_out_valid", int'(out_valid), 1);
        #1;
        reset = 1'b0;
        #1;
        check("async_rst_out_valid", int'(out_valid), 0);
        check("async_rst_out_data", int'(out_data), 0);
        check("async_rst_out_ch", int'(out_ch), 0);
        check("rst_queue_empty", q.size(), 0);
        q.delete();
        exp_done = 1'b0;
        @(negedge clk);
        reset   = 1'b1;
        bp_hold = 1'b0;
        @(posedge clk);
        #1;

        // Fresh frame after reset must start at x=y=c=0.
        set_ex(5, 7, 13, 15, 15, 13, 7, 5);
        send_frame(1'b0, 1'b0, 1'b0, -1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global bound so the run always terminates.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched so far", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
